// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM states,
// per-stage stall vectors and stage bit positions.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int CNT_W = 6;

  // Stage bit positions in the stall vector
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [5:0] STALL_MDU      = 6'b001111;
  localparam logic [5:0] STALL_MEM      = 6'b011111;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the ID source operands.
// Purely combinational; register 0 never hazards.
module hazard_detect (
  input  logic       i_ex_load,
  input  logic [4:0] i_ex_write_addr,
  input  logic       i_id_read_en_1,
  input  logic [4:0] i_id_read_addr_1,
  input  logic       i_id_read_en_2,
  input  logic [4:0] i_id_read_addr_2,
  output logic       o_load_use
);

  logic w_hit_1;
  logic w_hit_2;

  assign w_hit_1    = i_id_read_en_1 && (i_id_read_addr_1 == i_ex_write_addr);
  assign w_hit_2    = i_id_read_en_2 && (i_id_read_addr_2 == i_ex_write_addr);
  assign o_load_use = i_ex_load && (i_ex_write_addr != 5'd0) && (w_hit_1 || w_hit_2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: MDU wait, memory wait and load-use stalls.
// Define PIPELINE_CTRL_PERF_EN to build the saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int STAGE_NUM   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_load,
  input  logic [4:0]           ex_write_addr,
  input  logic                 id_read_en_1,
  input  logic                 id_read_en_2,
  input  logic [4:0]           id_read_addr_1,
  input  logic [4:0]           id_read_addr_2,
  input  logic                 id_mdu_start,
  input  logic                 mem_stall_req,
  input  logic                 branch_taken,
  output logic [STAGE_NUM-1:0] stall,
  output logic                 flush,
  output logic                 mdu_busy,
  output logic [31:0]          stall_cycles
);

  // The start cycle itself is stalled in RUN, so MDU_WAIT counts one fewer.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 2);

  state_e           r_state, w_nxt_state;
  state_e           r_prior, w_nxt_prior;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [5:0]       w_stall;
  logic             w_load_use;

  hazard_detect u_hazard (
    .i_ex_load        (ex_load),
    .i_ex_write_addr  (ex_write_addr),
    .i_id_read_en_1   (id_read_en_1),
    .i_id_read_addr_1 (id_read_addr_1),
    .i_id_read_en_2   (id_read_en_2),
    .i_id_read_addr_2 (id_read_addr_2),
    .o_load_use       (w_load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_prior <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_prior <= w_nxt_prior;
      r_cnt   <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_prior = r_prior;
    w_nxt_cnt   = r_cnt;
    w_stall     = STALL_NONE;

    if (r_state == ST_MEM_WAIT || mem_stall_req)
      w_stall = STALL_MEM;
    else if (r_state == ST_MDU_WAIT || (r_state == ST_RUN && id_mdu_start))
      w_stall = STALL_MDU;
    else if (w_load_use)
      w_stall = STALL_LOAD_USE;

    case (r_state)
      ST_RUN: begin
        if (mem_stall_req) begin
          w_nxt_state = ST_MEM_WAIT;
          w_nxt_prior = ST_RUN;
        end else if (id_mdu_start) begin
          w_nxt_state = ST_MDU_WAIT;
          w_nxt_cnt   = CNT_LOAD;
        end
      end
      ST_MDU_WAIT: begin
        // A memory wait parks the MDU countdown; cnt resumes on return.
        if (mem_stall_req) begin
          w_nxt_state = ST_MEM_WAIT;
          w_nxt_prior = ST_MDU_WAIT;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_RUN;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall_req) w_nxt_state = r_prior;
      end
      default: w_nxt_state = ST_RUN;
    endcase
  end

  assign stall    = STAGE_NUM'(w_stall);
  assign flush    = branch_taken && !stall[STG_ID];
  assign mdu_busy = (r_state == ST_MDU_WAIT);

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cycles <= '0;
    else if (stall[STG_PC] && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int L = 4;
`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_load, id_read_en_1, id_read_en_2, id_mdu_start, mem_stall_req, branch_taken;
  logic [4:0]  ex_write_addr, id_read_addr_1, id_read_addr_2;
  logic [5:0]  stall;
  logic        flush, mdu_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining MDU-stall cycles, memory-hold flag, perf count
  int          m_left;
  bit          m_hold;
  logic [31:0] m_perf;
  logic [5:0]  e_stall;
  logic        e_flush, e_busy;
  logic [31:0] e_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MDU_LATENCY(L), .STAGE_NUM(6)) dut (
    .clk(clk), .rst(rst), .ex_load(ex_load), .ex_write_addr(ex_write_addr),
    .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
    .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
    .id_mdu_start(id_mdu_start), .mem_stall_req(mem_stall_req),
    .branch_taken(branch_taken), .stall(stall), .flush(flush),
    .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  task automatic clr();
    ex_load = 0; ex_write_addr = 0; id_read_en_1 = 0; id_read_en_2 = 0;
    id_read_addr_1 = 0; id_read_addr_2 = 0; id_mdu_start = 0;
    mem_stall_req = 0; branch_taken = 0;
  endtask

  task automatic model_reset();
    m_left = 0; m_hold = 0; m_perf = 0;
  endtask

  // Expected outputs for the current inputs and model state
  task automatic eval();
    bit lu;
    lu = ex_load && ex_write_addr != 0 &&
         ((id_read_en_1 && id_read_addr_1 == ex_write_addr) ||
          (id_read_en_2 && id_read_addr_2 == ex_write_addr));
    if (m_hold || mem_stall_req)              e_stall = 6'b011111;
    else if (m_left > 0 || id_mdu_start)      e_stall = 6'b001111;
    else if (lu)                              e_stall = 6'b000111;
    else                                      e_stall = 6'b000000;
    e_flush = branch_taken && !e_stall[2];
    e_busy  = (m_left > 0) && !m_hold;
    e_cnt   = PERF ? m_perf : 32'd0;
  endtask

  // Clock edge: advance the model with the inputs held across the edge
  task automatic advance();
    @(posedge clk);
    if (m_hold || mem_stall_req) m_hold = mem_stall_req;
    else if (m_left > 0)         m_left = m_left - 1;
    else if (id_mdu_start)       m_left = L - 1;
    if (e_stall[0] && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    clr();
    rst = 0;
    model_reset();
    #2;
    checks++;
    if ({stall, flush, mdu_busy, stall_cycles} !== {6'b0, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset: got stall=%b flush=%b busy=%b cnt=%0d want all zero",
               stall, flush, mdu_busy, stall_cycles);
    end
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_load = 1; ex_write_addr = 5; id_read_en_1 = 1; id_read_addr_1 = 5;
    #2; eval();
    checks++;
    if (stall !== 6'b000111 || e_stall !== 6'b000111) begin
      failures++;
      $display("FAIL load_use_hit: got stall=%b want 000111", stall);
    end
    advance();
    clr(); #2;
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL load_use_next: got stall=%b want 000000", stall);
    end
    advance();
    ex_load = 1; ex_write_addr = 0; id_read_en_1 = 1; id_read_addr_1 = 0;
    id_read_en_2 = 1; id_read_addr_2 = 0; #2;
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL load_use_r0: got stall=%b want 000000", stall);
    end
    advance();
    ex_write_addr = 9; id_read_en_1 = 0; id_read_addr_1 = 9;
    id_read_en_2 = 1; id_read_addr_2 = 9; #2;
    checks++;
    if (stall !== 6'b000111) begin
      failures++;
      $display("FAIL load_use_port2: got stall=%b want 000111", stall);
    end
    advance();
    clr();
  endtask

  task automatic test_mdu();
    do_reset();
    id_mdu_start = 1; #2;
    checks++;
    if ({stall, mdu_busy} !== {6'b001111, 1'b0}) begin
      failures++;
      $display("FAIL mdu_c1: got stall=%b busy=%b want 001111/0", stall, mdu_busy);
    end
    advance();
    clr();
    for (int c = 2; c <= L; c++) begin
      #2;
      checks++;
      if ({stall, mdu_busy} !== {6'b001111, 1'b1}) begin
        failures++;
        $display("FAIL mdu_c%0d: got stall=%b busy=%b want 001111/1", c, stall, mdu_busy);
      end
      advance();
    end
    #2;
    checks++;
    if ({stall, mdu_busy} !== {6'b000000, 1'b0}) begin
      failures++;
      $display("FAIL mdu_done: got stall=%b busy=%b want 000000/0", stall, mdu_busy);
    end
    advance();
  endtask

  task automatic test_mem_in_mdu();
    int mdu_cycles = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clr();
      id_mdu_start  = (c == 0);
      mem_stall_req = (c >= 2 && c <= 4);
      #2; eval();
      checks++;
      if ({stall, flush, mdu_busy, stall_cycles} !== {e_stall, e_flush, e_busy, e_cnt}) begin
        failures++;
        $display("FAIL mem_in_mdu c%0d: got stall=%b busy=%b cnt=%0d want stall=%b busy=%b cnt=%0d",
                 c, stall, mdu_busy, stall_cycles, e_stall, e_busy, e_cnt);
      end
      if (mem_stall_req) begin
        checks++;
        if (stall !== 6'b011111) begin
          failures++;
          $display("FAIL mem_stall c%0d: got stall=%b want 011111", c, stall);
        end
      end
      if (stall === 6'b001111) mdu_cycles++;
      advance();
    end
    checks++;
    if (mdu_cycles != L) begin
      failures++;
      $display("FAIL mdu_total: got %0d mdu-stall cycles want %0d", mdu_cycles, L);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_load = 1; ex_write_addr = 7; id_read_en_2 = 1; id_read_addr_2 = 7;
    branch_taken = 1; #2;
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL branch_stalled: got flush=%b want 0", flush);
    end
    advance();
    ex_load = 0; #2;
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL branch_free: got flush=%b want 1", flush);
    end
    advance();
    clr();
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    id_mdu_start = 1; #2; eval();
    advance();
    clr(); #2; eval();
    advance();
    rst = 0; model_reset(); #1;
    checks++;
    if ({mdu_busy, stall_cycles, stall} !== {1'b0, 32'd0, 6'b0}) begin
      failures++;
      $display("FAIL reset_async: got busy=%b cnt=%0d stall=%b want 0/0/000000",
               mdu_busy, stall_cycles, stall);
    end
    #2; rst = 1;
    for (int c = 0; c < L + 1; c++) begin
      #1;
      checks++;
      if ({stall, mdu_busy} !== {6'b000000, 1'b0}) begin
        failures++;
        $display("FAIL reset_no_resume c%0d: got stall=%b busy=%b want 000000/0",
                 c, stall, mdu_busy);
      end
      eval(); advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ex_load        = $urandom_range(0, 1);
      ex_write_addr  = 5'($urandom_range(0, 6));
      id_read_en_1   = $urandom_range(0, 1);
      id_read_en_2   = $urandom_range(0, 1);
      id_read_addr_1 = 5'($urandom_range(0, 6));
      id_read_addr_2 = 5'($urandom_range(0, 6));
      id_mdu_start   = ($urandom_range(0, 7) == 0);
      mem_stall_req  = ($urandom_range(0, 5) == 0);
      branch_taken   = $urandom_range(0, 1);
      #2; eval();
      checks++;
      if ({stall, flush, mdu_busy, stall_cycles} !== {e_stall, e_flush, e_busy, e_cnt}) begin
        failures++;
        $display("FAIL random c%0d: got stall=%b flush=%b busy=%b cnt=%0d want stall=%b flush=%b busy=%b cnt=%0d",
                 c, stall, flush, mdu_busy, stall_cycles, e_stall, e_flush, e_busy, e_cnt);
      end
      advance();
    end
    clr();
  endtask

`ifdef PIPELINE_CTRL_PERF_EN
  task automatic test_perf();
    do_reset();
    ex_load = 1; ex_write_addr = 3; id_read_en_1 = 1; id_read_addr_1 = 3;
    for (int c = 0; c < 10; c++) begin
      #2; eval(); advance();
    end
    clr(); #2;
    checks++;
    if (stall_cycles !== 32'd10) begin
      failures++;
      $display("FAIL perf_10: got %0d want 10", stall_cycles);
    end
    dut.r_stall_cycles = 32'hFFFF_FFFE;
    m_perf = 32'hFFFF_FFFE;
    ex_load = 1; ex_write_addr = 3; id_read_en_1 = 1; id_read_addr_1 = 3;
    for (int c = 0; c < 3; c++) begin
      #2; eval(); advance();
    end
    clr(); #2;
    checks++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL perf_sat: got %h want ffffffff", stall_cycles);
    end
  endtask
`endif

  initial begin
    clr();
    rst = 1;
    model_reset();
    #1;
    test_reset();
    test_load_use();
    test_mdu();
    test_mem_in_mdu();
    test_branch();
    test_reset_mid_mdu();
    test_random();
`ifdef PIPELINE_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
